// File: rtl/press_game_ctrl_if.sv
// press_game_ctrl_if: drawer command/completion bus
// master issues draw commands, slave answers with draw_done
interface press_game_ctrl_if #(
  parameter int PH_W = 3
);
  logic            draw_req;
  logic            draw_item;
  logic            draw_erase;
  logic [PH_W-1:0] draw_pos;
  logic            draw_done;

  modport master (
    output draw_req,
    output draw_item,
    output draw_erase,
    output draw_pos,
    input  draw_done
  );

  modport slave (
    input  draw_req,
    input  draw_item,
    input  draw_erase,
    input  draw_pos,
    output draw_done
  );
endinterface

// File: rtl/press_game_ctrl.sv
// press_game_ctrl: sweeps a press across garbage lanes,
// sequences drawer commands and scores button hits
module press_game_ctrl #(
  parameter int N_LANES  = 4,
  parameter int SCORE_W  = 8,
  parameter int MAX_MISS = 3
) (
  input  logic                       CLOCK_50,
  input  logic                       reset_n,
  input  logic                       tick,
  input  logic                       hit_n,
  input  logic [$clog2(N_LANES)-1:0] rng,
  press_game_ctrl_if.master          draw,
  output logic [SCORE_W-1:0]         score,
  output logic [3:0]                 misses,
  output logic                       game_over
);
  localparam int LANE_W = $clog2(N_LANES);
  localparam int PH_W   = LANE_W + 1;
  localparam int P      = 2 * (N_LANES - 1);

  // draw states are consecutive so completion steps by +1
  typedef enum logic [2:0] {
    S_ERASE_GARB,
    S_DRAW_GARB,
    S_ERASE_PRESS,
    S_DRAW_PRESS,
    S_ARMED,
    S_SPENT,
    S_OVER
  } state_t;

  state_t state, state_d;

  logic [PH_W-1:0]    phase, phase_d;
  logic [PH_W-1:0]    prev_phase, prev_phase_d;
  logic [LANE_W-1:0]  garb, garb_d;
  logic [LANE_W-1:0]  prev_garb, prev_garb_d;
  logic [SCORE_W-1:0] score_d;
  logic [3:0]         misses_d;
  logic               over_d;
  logic               pending, pending_d;
  logic               sent, sent_d;
  logic               req, req_d;
  logic               item, item_d;
  logic               erase, erase_d;
  logic [PH_W-1:0]    pos, pos_d;

  logic [2:0]         sync;
  logic               fall;
  logic               on_lane;
  logic               step;
  logic [PH_W-1:0]    phase_nxt;
  logic [3:0]         miss_inc;

  function automatic logic [LANE_W-1:0] lane_of(
    input logic [PH_W-1:0] ph
  );
    logic [PH_W-1:0] m;
    m = (ph < PH_W'(N_LANES)) ? ph : PH_W'(P) - ph;
    return m[LANE_W-1:0];
  endfunction

  assign fall      = sync[2] & ~sync[1];
  assign on_lane   = lane_of(phase) == garb;
  assign step      = tick | pending;
  assign miss_inc  = misses + 4'd1;
  assign phase_nxt = (phase == PH_W'(P - 1)) ?
                     '0 : phase + PH_W'(1);

  assign draw.draw_req   = req;
  assign draw.draw_item  = item;
  assign draw.draw_erase = erase;
  assign draw.draw_pos   = pos;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      sync <= '1;
    end else begin
      sync <= {sync[1:0], hit_n};
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_ERASE_GARB;
      phase      <= '0;
      prev_phase <= '0;
      garb       <= '0;
      prev_garb  <= '0;
      score      <= '0;
      misses     <= '0;
      game_over  <= 1'b0;
      pending    <= 1'b0;
      sent       <= 1'b0;
      req        <= 1'b0;
      item       <= 1'b0;
      erase      <= 1'b0;
      pos        <= '0;
    end else begin
      state      <= state_d;
      phase      <= phase_d;
      prev_phase <= prev_phase_d;
      garb       <= garb_d;
      prev_garb  <= prev_garb_d;
      score      <= score_d;
      misses     <= misses_d;
      game_over  <= over_d;
      pending    <= pending_d;
      sent       <= sent_d;
      req        <= req_d;
      item       <= item_d;
      erase      <= erase_d;
      pos        <= pos_d;
    end
  end

  always_comb begin
    state_d      = state;
    phase_d      = phase;
    prev_phase_d = prev_phase;
    garb_d       = garb;
    prev_garb_d  = prev_garb;
    score_d      = score;
    misses_d     = misses;
    over_d       = game_over;
    pending_d    = pending;
    sent_d       = sent;
    req_d        = 1'b0;
    item_d       = item;
    erase_d      = erase;
    pos_d        = pos;

    unique case (state)
      S_ERASE_GARB, S_DRAW_GARB,
      S_ERASE_PRESS, S_DRAW_PRESS: begin
        if (tick) pending_d = 1'b1;
        if (!sent) begin
          req_d   = 1'b1;
          sent_d  = 1'b1;
          item_d  = state == S_ERASE_PRESS ||
                    state == S_DRAW_PRESS;
          erase_d = state == S_ERASE_GARB ||
                    state == S_ERASE_PRESS;
          unique case (1'b1)
            state == S_ERASE_GARB:  pos_d = {1'b0, prev_garb};
            state == S_DRAW_GARB:   pos_d = {1'b0, garb};
            state == S_ERASE_PRESS: pos_d = prev_phase;
            default:                pos_d = phase;
          endcase
        // done in the req cycle itself is not ours
        end else if (!req && draw.draw_done) begin
          sent_d  = 1'b0;
          state_d = state_t'(state + 3'd1);
          if (state == S_DRAW_PRESS) begin
            prev_garb_d  = garb;
            prev_phase_d = phase;
          end
        end
      end
      S_ARMED: begin
        if (fall && on_lane) begin
          score_d   = (&score) ? score
                    : score + SCORE_W'(1);
          garb_d    = rng;
          state_d   = S_SPENT;
          pending_d = step;
        end else if (step) begin
          pending_d = 1'b0;
          phase_d   = phase_nxt;
          state_d   = S_ERASE_GARB;
          if (on_lane) begin
            misses_d = miss_inc;
            if (miss_inc == 4'(MAX_MISS)) begin
              state_d = S_OVER;
              over_d  = 1'b1;
            end
          end
        end
      end
      S_SPENT: begin
        if (step) begin
          pending_d = 1'b0;
          phase_d   = phase_nxt;
          state_d   = S_ERASE_GARB;
        end
      end
      default: begin
        pending_d = 1'b0;
        over_d    = 1'b1;
      end
    endcase
  end
endmodule

// File: tb/tb_press_game_ctrl.sv
// tb_press_game_ctrl: randomized games checked against a
// step-level game model and a 3-cycle drawer model
module tb_press_game_ctrl;
  localparam int N  = 4;
  localparam int SW = 4;
  localparam int MM = 3;
  localparam int LW = 2;
  localparam int PW = 3;
  localparam int P  = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tick = 1'b0;
  logic          hit_n = 1'b1;
  logic [LW-1:0] rng = '0;
  logic [SW-1:0] score;
  logic [3:0]    misses;
  logic          game_over;

  press_game_ctrl_if #(.PH_W(PW)) dif ();

  press_game_ctrl #(
    .N_LANES (N),
    .SCORE_W (SW),
    .MAX_MISS(MM)
  ) dut (
    .CLOCK_50 (clk),
    .reset_n  (rst_n),
    .tick     (tick),
    .hit_n    (hit_n),
    .rng      (rng),
    .draw     (dif),
    .score    (score),
    .misses   (misses),
    .game_over(game_over)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [4:0] cmd_q[$];
  logic [4:0] cur;
  int         dcnt = 0;

  int m_phase, m_pphase, m_garb, m_pgarb;
  int m_score, m_miss;
  bit m_over, m_spent;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  function automatic int lane(input int ph);
    return (ph < N) ? ph : P - ph;
  endfunction

  function automatic logic [4:0] mk(input int it,
                                    input int er,
                                    input int ps);
    logic [4:0] v;
    v = {1'(it), 1'(er), 3'(ps)};
    return v;
  endfunction

  // drawer: one command in flight, done 3 cycles after req
  initial begin
    dif.draw_done = 1'b0;
    cur = '0;
    forever begin
      @(posedge clk);
      #1;
      dif.draw_done = 1'b0;
      if (!rst_n) begin
        dcnt = 0;
      end else begin
        if (dcnt > 0) begin
          dcnt--;
          if (dcnt == 0) begin
            dif.draw_done = 1'b1;
            cmd_q.push_back(cur);
          end
        end
        if (dif.draw_req) begin
          dcnt = 3;
          cur = {dif.draw_item, dif.draw_erase, dif.draw_pos};
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_phase = 0; m_pphase = 0;
    m_garb = 0; m_pgarb = 0;
    m_score = 0; m_miss = 0;
    m_over = 0; m_spent = 0;
  endtask

  task automatic model_hit(input int r);
    if (!m_spent && lane(m_phase) == m_garb) begin
      m_score = (m_score == (1 << SW) - 1) ?
                m_score : m_score + 1;
      m_garb  = r;
      m_spent = 1;
    end
  endtask

  task automatic model_tick();
    if (!m_spent && lane(m_phase) == m_garb) begin
      m_miss++;
      if (m_miss == MM) m_over = 1;
    end
    m_phase = (m_phase + 1) % P;
  endtask

  task automatic press(input int hold, input int r);
    rng = LW'(r);
    hit_n = 1'b0;
    repeat (hold) cyc();
    hit_n = 1'b1;
    repeat (5) cyc();
    model_hit(r);
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
  endtask

  // hit edge and tick land in the same ARMED cycle
  task automatic hit_with_tick(input int r);
    rng = LW'(r);
    hit_n = 1'b0;
    cyc();
    cyc();
    pulse_tick();
    cyc();
    hit_n = 1'b1;
    model_hit(r);
    model_tick();
  endtask

  task automatic wait_cmds(input int n, input string tag);
    int k;
    k = 0;
    while (cmd_q.size() < n && k < 200) begin
      cyc();
      k++;
    end
    if (cmd_q.size() < n) check(tag, cmd_q.size(), n);
  endtask

  task automatic run_step(input int hit_pct,
                          input int mid_pct,
                          output bit over_o);
    logic [4:0] e[4];
    logic [4:0] g;
    bit mid;
    e[0] = mk(0, 1, m_pgarb);
    e[1] = mk(0, 0, m_garb);
    e[2] = mk(1, 1, m_pphase);
    e[3] = mk(1, 0, m_phase);
    mid = $urandom_range(99) < mid_pct;
    over_o = 0;

    wait_cmds(1, "first_done_timeout");
    if ($urandom_range(1) == 1) begin
      hit_n = 1'b0;
      repeat (2) cyc();
      hit_n = 1'b1;
    end
    if (mid) begin
      repeat ($urandom_range(3)) cyc();
      pulse_tick();
      if ($urandom_range(1) == 1) begin
        cyc();
        pulse_tick();
      end
    end
    wait_cmds(4, "draw_done_timeout");
    cyc();
    for (int i = 0; i < 4; i++) begin
      g = (cmd_q.size() > 0) ? cmd_q.pop_front() : 5'h1f;
      check($sformatf("cmd%0d", i), g, e[i]);
    end
    m_pgarb  = m_garb;
    m_pphase = m_phase;
    m_spent  = 0;

    if (mid) begin
      model_tick();
    end else if (lane(m_phase) == m_garb &&
                 $urandom_range(99) < hit_pct) begin
      if ($urandom_range(2) == 0) begin
        hit_with_tick($urandom_range(3));
      end else begin
        press($urandom_range(1, 10), $urandom_range(3));
        if ($urandom_range(1) == 1)
          press($urandom_range(1, 4), $urandom_range(3));
        check("score_armed", score, m_score);
        pulse_tick();
        model_tick();
      end
    end else begin
      if (lane(m_phase) != m_garb &&
          $urandom_range(2) == 0)
        press($urandom_range(1, 6), $urandom_range(3));
      pulse_tick();
      model_tick();
    end
    cyc();
    check("score", score, m_score);
    check("misses", misses, m_miss);
    check("game_over", game_over, m_over);

    if (m_over) begin
      repeat (3) begin
        pulse_tick();
        repeat (2) cyc();
      end
      press(2, 1);
      repeat (10) cyc();
      check("no_draw_when_over", cmd_q.size(), 0);
      check("score_frozen", score, m_score);
      check("over_held", game_over, 1);
      over_o = 1;
    end
  endtask

  task automatic game(input int steps,
                      input int hit_pct,
                      input int mid_pct);
    bit ov;
    ov = 0;
    for (int s = 0; s < steps && !ov; s++)
      run_step(hit_pct, mid_pct, ov);
  endtask

  task automatic reset_checks();
    check("rst_score", score, 0);
    check("rst_misses", misses, 0);
    check("rst_game_over", game_over, 0);
    check("rst_req", dif.draw_req, 0);
    check("rst_item", dif.draw_item, 0);
    check("rst_erase", dif.draw_erase, 0);
    check("rst_pos", dif.draw_pos, 0);
  endtask

  task automatic release_reset();
    cmd_q.delete();
    rst_n = 1'b1;
    model_reset();
    cyc();
    check("first_req", dif.draw_req, 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    reset_checks();
    cyc();
    cyc();
    release_reset();
  endtask

  initial begin
    repeat (3) cyc();
    reset_checks();
    release_reset();
    game(30, 70, 25);
    do_reset();
    game(90, 100, 0);
    do_reset();
    game(40, 0, 0);
    check("final_game_over", game_over, 1);
    repeat (2) cyc();
    do_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/press_game_ctrl.md
PRESS_GAME_CTRL -- requirements
Module: press_game_ctrl

Interface
REQ-001 SHALL have parameter N_LANES, default 4: garbage lanes; power of two, 2..16.
REQ-002 SHALL have parameter SCORE_W, default 8: score width.
REQ-003 SHALL have parameter MAX_MISS, default 3: misses before game over; 1..15.
REQ-004 SHALL derive LANE_W = log2(N_LANES), PH_W = LANE_W+1, P = 2*(N_LANES-1) press phases.
REQ-005 SHALL have port CLOCK_50  in  1  the single clock.
REQ-006 SHALL have port reset_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port tick  in  1  one-cycle step pulse from the rate divider.
REQ-008 SHALL have port hit_n  in  1  raw hit button, active-low, asynchronous to CLOCK_50.
REQ-009 SHALL have port rng  in  LANE_W  random lane from the random-number generator.
REQ-010 SHALL have port draw_req  out  1  one-cycle drawer command strobe.
REQ-011 SHALL have port draw_item  out  1  0 = garbage sprite, 1 = press sprite.
REQ-012 SHALL have port draw_erase  out  1  1 = erase, 0 = draw.
REQ-013 SHALL have port draw_pos  out  PH_W  lane (garbage) or phase (press).
REQ-014 SHALL have port draw_done  in  1  drawer completion pulse.
REQ-015 SHALL have ports score  out  SCORE_W, misses  out  4, game_over  out  1.

Function
REQ-016 SHALL sweep phase 0..P-1, wrapping to 0; phase advances by 1 on each accepted tick.
REQ-017 SHALL map lane(phase) = phase if phase < N_LANES, else P-phase (4 lanes: phases 4,5 -> lanes 2,1).
REQ-018 SHALL run states ERASE_GARB -> DRAW_GARB -> ERASE_PRESS -> DRAW_PRESS -> ARMED; ARMED -> SPENT on valid hit; any of ARMED/SPENT -> ERASE_GARB on tick; OVER is terminal.
REQ-019 SHALL pulse draw_req for one cycle on entry to each draw state, holding item/erase/pos stable until draw_done.
REQ-020 SHALL leave a draw state the cycle after draw_done, sampling draw_done only from the cycle after draw_req.
REQ-021 SHALL command: ERASE_GARB (0,1,prev_garb); DRAW_GARB (0,0,garb); ERASE_PRESS (1,1,prev_phase); DRAW_PRESS (1,0,phase).
REQ-022 SHALL latch prev_garb <= garb and prev_phase <= phase when DRAW_PRESS completes.
REQ-023 SHALL synchronise hit_n through two flops and detect its falling edge; a held button counts once.
REQ-024 SHALL treat a hit edge as valid only in ARMED with lane(phase) == garb; all other edges discarded.
REQ-025 SHALL, on valid hit: score +1 saturating at all-ones, garb <= rng, enter SPENT.
REQ-026 SHALL record a tick arriving in a draw state as pending (one deep; further ticks dropped) and accept it on entering ARMED.
REQ-027 SHALL, on tick accepted in ARMED with lane(phase) == garb, increment misses.
REQ-028 SHALL enter OVER when misses reaches MAX_MISS; game_over = 1; ticks and hits ignored; no draw_req.
REQ-029 SHALL, on tick and valid hit in the same ARMED cycle, score the hit, count no miss, and start the next step the following cycle.
REQ-030 SHALL keep all outputs registered; no combinational input-to-output path.

Reset
REQ-031 SHALL asynchronously clear state to ERASE_GARB, phase/prev_phase/garb/prev_garb/score/misses/pending to 0, draw_req/draw_item/draw_erase/draw_pos/game_over to 0.
REQ-032 SHALL issue the first draw_req on the first clock edge after reset_n deasserts.
REQ-033 SHALL abandon any in-flight drawer operation on reset; a later stale draw_done is ignored until a new draw_req.

Verification (N_LANES=4, drawer model returns draw_done 3 cycles after draw_req)
REQ-034 Release reset, no tick -> four draw_req pulses: (0,1,0),(0,0,0),(1,1,0),(1,0,0); then ARMED, score 0.
REQ-035 Phase 0, garb 0, hit_n low for 10 cycles in ARMED, rng=2 -> score 1 (once only), next step erases lane 0, draws lane 2.
REQ-036 Six ticks with no hits, garb 2 -> phases 1,2,3,4,5,0; misses increments at ticks leaving phases 2 and 4.
REQ-037 Tick asserted mid DRAW_GARB -> no effect until ARMED, then exactly one step begins, phase +1.
REQ-038 MAX_MISS=3, three misses -> game_over 1, further ticks produce no draw_req; reset_n low -> all outputs 0.
REQ-039 Score 8'hFF, valid hit -> score stays 8'hFF, garb reloaded from rng.
